// File: rtl/wshb_arb_pkg.sv
// Shared types and Wishbone cycle-type constants for the SDRAM port arbiter.
package wshb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_rr_arbiter_rr_picker.sv
// Round-robin picker: one-hot of the first set request bit at or after ptr_i, wrapping cyclically.
module rr_picker #(
    parameter  int NM = 2,
    localparam int PW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NM-1:0] pick_o
);

    localparam logic [PW:0] NM_W = (PW+1)'(NM);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan requesters starting at the pointer; the extra sum bit holds the wrap before the modulo.
    always_comb begin
        pick_o  = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NM; i++) begin
            sum_s = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum_s >= NM_W) begin
                sum_s = sum_s - NM_W;
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && req_i[idx_s]) begin
                pick_o[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/wshb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM slave port between NM masters,
// with a per-grant termination quota so long bursts cannot starve other masters.
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter  int NM       = 2,
    parameter  int DW       = 32,
    parameter  int AW       = 32,
    parameter  int MAX_XFER = 16,
    localparam int SW       = DW / 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NM-1:0]          m_cyc,
    input  logic [NM-1:0]          m_stb,
    input  logic [NM-1:0]          m_we,
    input  logic [NM-1:0][AW-1:0]  m_adr,
    input  logic [NM-1:0][DW-1:0]  m_dat_ms,
    input  logic [NM-1:0][SW-1:0]  m_sel,
    input  logic [NM-1:0][2:0]     m_cti,
    input  logic [NM-1:0][1:0]     m_bte,
    output logic [NM-1:0]          m_ack,
    output logic [NM-1:0]          m_err,
    output logic [NM-1:0]          m_rty,
    output logic [DW-1:0]          m_dat_sm,
    output logic                   s_cyc,
    output logic                   s_stb,
    output logic                   s_we,
    output logic [AW-1:0]          s_adr,
    output logic [DW-1:0]          s_dat_ms,
    output logic [SW-1:0]          s_sel,
    output logic [2:0]             s_cti,
    output logic [1:0]             s_bte,
    input  logic                   s_ack,
    input  logic                   s_err,
    input  logic                   s_rty,
    input  logic [DW-1:0]          s_dat_sm,
    output logic [NM-1:0]          gnt
);

    localparam int            PW       = (NM > 1) ? $clog2(NM) : 1;
    localparam int            CW       = (MAX_XFER > 0) ? $clog2(MAX_XFER + 1) : 1;
    localparam logic          QUOTA_EN = (MAX_XFER > 0);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_XFER);
    localparam logic [CW-1:0] CNT_LAST = (MAX_XFER > 0) ? CW'(MAX_XFER - 1) : '0;
    localparam logic [PW-1:0] IDX_LAST = PW'(NM - 1);

    state_t        state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d, pick_s;
    logic [PW-1:0] ptr_q, ptr_d, gidx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          term_s, others_s, quota_s, release_s;

    rr_picker #(.NM(NM)) u_picker (
        .req_i  (m_cyc),
        .ptr_i  (ptr_q),
        .pick_o (pick_s)
    );

    // Binary index of the one-hot grant, used to steer the muxes.
    always_comb begin
        gidx_s = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_q[i]) begin
                gidx_s = PW'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
    end

    // Quota release waits for a non-incrementing beat so a linear burst is never split.
    assign term_s    = (state_q == GRANT) && (s_ack || s_err || s_rty);
    assign others_s  = |(m_cyc & ~gnt_q);
    assign quota_s   = QUOTA_EN && term_s && (cnt_q >= CNT_LAST) && (m_cti[gidx_s] != CTI_INCR) && others_s;
    assign release_s = (state_q == GRANT) && (!m_cyc[gidx_s] || quota_s);
    assign gnt       = gnt_q;

    // State register with asynchronous reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: grant from IDLE, release back to IDLE; cnt saturates instead of wrapping.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|m_cyc) begin
                    gnt_d   = pick_s;
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    ptr_d   = (gidx_s == IDX_LAST) ? '0 : gidx_s + 1'b1;
                end else if (term_s && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output muxes: slave side follows the granted master, responses go to that master only.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        m_dat_sm = s_dat_sm;
        if (state_q == GRANT) begin
            s_cyc    = m_cyc[gidx_s];
            s_stb    = m_stb[gidx_s];
            s_we     = m_we[gidx_s];
            s_adr    = m_adr[gidx_s];
            s_dat_ms = m_dat_ms[gidx_s];
            s_sel    = m_sel[gidx_s];
            s_cti    = m_cti[gidx_s];
            s_bte    = m_bte[gidx_s];
            m_ack    = gnt_q & {NM{s_ack}};
            m_err    = gnt_q & {NM{s_err}};
            m_rty    = gnt_q & {NM{s_rty}};
        end else begin
            s_cyc = 1'b0;
        end
    end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Self-checking bench for wshb_rr_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_wshb_rr_arbiter;

    localparam int NM    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int SW    = DW / 8;
    localparam int QUOTA = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    logic [NM-1:0]          m_cyc, m_stb, m_we;
    logic [NM-1:0][AW-1:0]  m_adr;
    logic [NM-1:0][DW-1:0]  m_dat_ms;
    logic [NM-1:0][SW-1:0]  m_sel;
    logic [NM-1:0][2:0]     m_cti;
    logic [NM-1:0][1:0]     m_bte;
    logic [NM-1:0]          m_ack, m_err, m_rty, gnt;
    logic [DW-1:0]          m_dat_sm;
    logic                   s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [AW-1:0]          s_adr;
    logic [DW-1:0]          s_dat_ms, s_dat_sm;
    logic [SW-1:0]          s_sel;
    logic [2:0]             s_cti;
    logic [1:0]             s_bte;
    logic [1:0]             resp;   // slave response: 0 none, 1 ack, 2 err, 3 rty

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    assign s_ack    = s_cyc & s_stb & (resp == 2'd1);
    assign s_err    = s_cyc & s_stb & (resp == 2'd2);
    assign s_rty    = s_cyc & s_stb & (resp == 2'd3);
    assign s_dat_sm = s_adr ^ 32'hA5A5_5A5A;

    wshb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .MAX_XFER(QUOTA)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_ms(m_dat_ms),
        .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
        .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .gnt(gnt)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic quiet();
        m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
        m_sel = '0; m_dat_ms = '0; resp = 2'd0;
        m_adr[0] = 32'h1000_0040;
        m_adr[1] = 32'h2000_0080;
    endtask

    task automatic do_reset();
        quiet();
        sys_rst_n = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        quiet();
        sys_rst_n = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11; resp = 2'd1;
        #1;
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_scyc: got %b want 0", s_cyc); end
        tick();
        n_cmp++; if ({m_ack, m_err, m_rty} !== 6'b0) begin n_bad++; $display("FAIL reset_rsp: got %b want 000000", {m_ack, m_err, m_rty}); end
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt_held: got %b want 00", gnt); end
    endtask

    task automatic test_single();
        logic [DW-1:0] want_dat;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        #1;
        n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc); end
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
        n_cmp++; if (s_adr !== 32'h1000_0040) begin n_bad++; $display("FAIL single_adr: got %h want 10000040", s_adr); end
        resp = 2'd1;
        #1;
        n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", m_ack); end
        want_dat = 32'h1000_0040 ^ 32'hA5A5_5A5A;
        n_cmp++; if (m_dat_sm !== want_dat) begin n_bad++; $display("FAIL single_rdata: got %h want %h", m_dat_sm, want_dat); end
        quiet();
        tick();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL single_release: got %b want 00", gnt); end
    endtask

    task automatic test_simul();
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL simul_first: got %b want 01", gnt); end
        m_cyc = 2'b10; m_stb = 2'b10;
        tick();
        n_cmp++; if ({gnt, s_cyc} !== 3'b000) begin n_bad++; $display("FAIL simul_gap: gnt,s_cyc got %b want 000", {gnt, s_cyc}); end
        tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL simul_second: got %b want 10", gnt); end
        n_cmp++; if (s_adr !== 32'h2000_0080) begin n_bad++; $display("FAIL simul_adr: got %h want 20000080", s_adr); end
        quiet();
        tick();
    endtask

    // Quota test; with burst=1 master0 runs an 8-beat incrementing burst instead of classic reads.
    task automatic test_quota(input bit burst);
        int beats;
        beats = burst ? 8 : QUOTA;
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL quota_grant(burst=%0d): got %b want 01", burst, gnt); end
        m_cyc = 2'b11; m_stb = 2'b11; resp = 2'd1;
        for (int k = 1; k <= beats; k++) begin
            m_cti[0] = !burst ? 3'b000 : (k == beats) ? 3'b111 : 3'b010;
            #1;
            n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL quota_ack(burst=%0d,beat=%0d): got %b want 01", burst, k, m_ack); end
            tick();
            if (k < beats) begin
                n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL quota_hold(burst=%0d,beat=%0d): got %b want 01", burst, k, gnt); end
            end else begin
                n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL quota_release(burst=%0d): got %b want 00", burst, gnt); end
            end
        end
        n_cmp++; if (m_ack !== 2'b00) begin n_bad++; $display("FAIL quota_stall(burst=%0d): got %b want 00", burst, m_ack); end
        tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL quota_next(burst=%0d): got %b want 10", burst, gnt); end
        n_cmp++; if (m_ack !== 2'b10) begin n_bad++; $display("FAIL quota_next_ack(burst=%0d): got %b want 10", burst, m_ack); end
        quiet();
        tick();
    endtask

    task automatic test_solo();
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        resp = 2'd1;
        for (int k = 0; k < 20; k++) begin
            #1;
            n_cmp++; if ({gnt, s_cyc, m_ack} !== 5'b01101) begin n_bad++; $display("FAIL solo_hold(ack=%0d): gnt,s_cyc,m_ack got %b want 01101", k, {gnt, s_cyc, m_ack}); end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        quiet();
        tick();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        resp = 2'd1;
        #1;
        n_cmp++; if (m_ack !== 2'b01) begin n_bad++; $display("FAIL rstmid_pre: m_ack got %b want 01", m_ack); end
        sys_rst_n = 1'b0;
        #1;
        n_cmp++; if ({s_cyc, gnt, m_ack} !== 5'b0) begin n_bad++; $display("FAIL rstmid_drop: s_cyc,gnt,m_ack got %b want 00000", {s_cyc, gnt, m_ack}); end
        m_cyc = 2'b11; m_stb = 2'b11; resp = 2'd0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rstmid_ptr: got %b want 01", gnt); end
        quiet();
        tick();
    endtask

    // Random masters against a model that tracks owner, pointer and terminations per grant.
    task automatic test_random();
        int mg, mptr, mn, r, pick;
        bit busy [NM];
        bit burst [NM];
        int rem [NM];
        bit hit, term, others, rel;
        logic [NM-1:0] e_gnt;
        logic [75:0]   e_bus;
        logic [5:0]    e_rsp;
        do_reset();
        mg = -1; mptr = 0; mn = 0;
        for (int i = 0; i < NM; i++) begin busy[i] = 1'b0; burst[i] = 1'b0; rem[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!busy[i] && ($urandom_range(0, 3) == 0)) begin
                    busy[i]  = 1'b1;
                    rem[i]   = $urandom_range(1, 10);
                    burst[i] = 1'($urandom_range(0, 1));
                    m_adr[i] = $urandom;
                end
                m_cyc[i]    = busy[i];
                m_stb[i]    = busy[i];
                m_cti[i]    = !busy[i] ? 3'b000 : !burst[i] ? 3'b000 : (rem[i] == 1) ? 3'b111 : 3'b010;
                m_we[i]     = 1'($urandom);
                m_sel[i]    = 4'($urandom);
                m_dat_ms[i] = $urandom;
                m_bte[i]    = 2'($urandom);
            end
            r = $urandom_range(0, 9);
            resp = (r < 6) ? 2'd1 : (r == 6) ? 2'd2 : (r == 7) ? 2'd3 : 2'd0;
            #1;
            e_gnt = '0;
            e_bus = '0;
            hit   = 1'b0;
            if (mg >= 0) begin
                e_gnt[mg] = 1'b1;
                e_bus = {m_cyc[mg], m_stb[mg], m_we[mg], m_adr[mg], m_dat_ms[mg], m_sel[mg], m_cti[mg], m_bte[mg]};
                hit   = m_cyc[mg] && m_stb[mg];
            end
            e_rsp = {(hit && resp == 2'd1) ? e_gnt : 2'b00,
                     (hit && resp == 2'd2) ? e_gnt : 2'b00,
                     (hit && resp == 2'd3) ? e_gnt : 2'b00};
            n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rand_gnt(cycle=%0d): got %b want %b", c, gnt, e_gnt); end
            n_cmp++; if ({s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte} !== e_bus) begin
                n_bad++; $display("FAIL rand_bus(cycle=%0d): got %h want %h", c, {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}, e_bus);
            end
            n_cmp++; if ({m_ack, m_err, m_rty} !== e_rsp) begin n_bad++; $display("FAIL rand_rsp(cycle=%0d): got %b want %b", c, {m_ack, m_err, m_rty}, e_rsp); end
            if (mg < 0) begin
                pick = -1;
                for (int k = 0; k < NM; k++) begin
                    if (pick < 0 && m_cyc[(mptr + k) % NM]) pick = (mptr + k) % NM;
                end
                mg = pick;
                mn = 0;
            end else begin
                term   = hit && (resp != 2'd0);
                others = (m_cyc & ~e_gnt) != '0;
                rel    = 1'b0;
                if (!m_cyc[mg]) begin
                    rel = 1'b1;
                end else if (term) begin
                    mn++;
                    rel = (mn >= QUOTA) && (m_cti[mg] != 3'b010) && others;
                end
                if (rel) begin
                    mptr = (mg + 1) % NM;
                    mg   = -1;
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (m_ack[i] || m_err[i] || m_rty[i]) begin
                    rem[i]--;
                    if (rem[i] <= 0) busy[i] = 1'b0;
                    m_adr[i] = m_adr[i] + 32'd4;
                end
            end
            tick();
        end
        quiet();
        tick();
        tick();
    endtask

    initial begin
        quiet();
        test_reset();
        test_single();
        test_simul();
        test_quota(1'b0);
        test_quota(1'b1);
        test_solo();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
